// File: rtl/cic_dec_ctrl_pkg.sv
// Shared types and helpers for the CIC decimator run-time sequencer.
// Holds the sequencer state encoding, default parameter values and the
// conversion from log2 decimation factor to the terminal phase count.
package cic_dec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int K_MAX_DEF     = 4;
  localparam int CIC_ORDER_DEF = 3;
  localparam int FLUSH_CYC_DEF = 2;

  // D-1 for D = 2^k; the phase counter wraps when it reaches this value.
  // Factors above 16 cannot reach the CIC, so they saturate at 15.
  function automatic logic [3:0] k_to_dm1(input logic [2:0] k);
    case (k)
      3'd0:    k_to_dm1 = 4'd0;
      3'd1:    k_to_dm1 = 4'd1;
      3'd2:    k_to_dm1 = 4'd3;
      3'd3:    k_to_dm1 = 4'd7;
      default: k_to_dm1 = 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/cic_dec_ctrl_phase_cnt.sv
// Modulo-D phase counter for the CIC sequencer.
// Counts accepted samples from 0 to max_val and flags the wrap back to 0.
// The wrap flag is combinational so the caller can register a strobe
// on the cycle after the terminal sample.
module cic_phase_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] max_val,
  output logic       wrap
);

  logic [3:0] ph;

  assign wrap = en && (ph == max_val);

  // Phase register: cleared by reset or flush, advances on each accepted sample.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ph <= 4'd0;
    end else if (en) begin
      ph <= wrap ? 4'd0 : ph + 4'd1;
    end
  end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Run-time sequencer for the 3-stage CIC decimator.
// Owns the CIC enable, decimation factor, bypass and flush; accepts
// configuration over a valid/ready handshake, applies a changed factor only
// through a flush, discards settling outputs and strobes out_valid once per
// decimated sample.
// Optional build macro: CIC_DEC_CTRL_GAIN_EN adds the gain_shift output.
//
// Handshake: a configuration request is taken in any cycle where
// cfg_valid && cfg_ready; cfg_ready depends only on state (IDLE or RUN), never
// on cfg_valid, and the requester must hold its fields stable while waiting.
module cic_dec_ctrl
  import cic_dec_ctrl_pkg::*;
#(
  parameter int K_MAX     = K_MAX_DEF,
  parameter int CIC_ORDER = CIC_ORDER_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_valid,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_dec_k,
  input  logic       cfg_bypass,
  output logic       cfg_err,
  output logic       cic_en,
  output logic       cic_clr,
  output logic [2:0] cic_dec_k,
  output logic       cic_bypass,
  output logic       out_valid,
  output logic       busy,
`ifdef CIC_DEC_CTRL_GAIN_EN
  output logic [3:0] gain_shift,
`endif
  output logic [1:0] dbg_state
);

  localparam logic [2:0] K_MAX_L     = 3'(K_MAX);
  localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(CIC_ORDER - 1);

  state_t     state;
  state_t     next_state;
  logic [2:0] shadow_k;
  logic       shadow_byp;
  logic [2:0] shadow_k_d;
  logic       shadow_byp_d;
  logic [3:0] flush_cnt;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       k_legal;
  logic       accept_ok;
  logic       cfg_differs;
  logic       flush_entry;
  logic       flush_last;
  logic       ph_clr;
  logic       wrap;

  assign cfg_ready   = (state == IDLE) || (state == RUN);
  assign accept      = cfg_valid && cfg_ready;
  assign k_legal     = (cfg_dec_k <= K_MAX_L);
  assign accept_ok   = accept && k_legal;
  // The value the shadow holds after this edge; FLUSH entry loads from it so
  // a request taken in the same cycle is applied without an extra delay.
  assign shadow_k_d   = accept_ok ? cfg_dec_k  : shadow_k;
  assign shadow_byp_d = accept_ok ? cfg_bypass : shadow_byp;
  assign cfg_differs = (cfg_dec_k != cic_dec_k) || (cfg_bypass != cic_bypass);
  assign cic_en      = in_valid && ((state == SETTLE) || (state == RUN));
  assign busy        = (state == FLUSH) || (state == SETTLE);
  assign flush_last  = (flush_cnt == FLUSH_LAST);
  assign flush_entry = (next_state == FLUSH) && (state != FLUSH);
  assign ph_clr      = (state == IDLE) || (state == FLUSH);
  assign dbg_state   = state;

  cic_phase_cnt u_phase (
    .clk     (clk),
    .rst     (rst),
    .clr     (ph_clr),
    .en      (cic_en),
    .max_val (k_to_dm1(cic_dec_k)),
    .wrap    (wrap)
  );

  // Next-state logic; a falling enable overrides every other event.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = FLUSH;
        FLUSH:   if (flush_last) next_state = cic_bypass ? RUN : SETTLE;
        SETTLE:  if (wrap && (settle_cnt == SETTLE_LAST)) next_state = RUN;
        RUN:     if (accept_ok && cfg_differs) next_state = FLUSH;
        default: next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flush-length and settle counters; both restart whenever a flush begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt  <= 4'd0;
      settle_cnt <= 4'd0;
    end else begin
      flush_cnt <= (state == FLUSH) ? flush_cnt + 4'd1 : 4'd0;
      if (ph_clr) begin
        settle_cnt <= 4'd0;
      end else if ((state == SETTLE) && wrap) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  // Shadow/active configuration, flush strobe, error pulse and output strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_k   <= 3'd0;
      shadow_byp <= 1'b0;
      cic_dec_k  <= 3'd0;
      cic_bypass <= 1'b0;
      cic_clr    <= 1'b1;
      cfg_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept_ok) begin
        shadow_k   <= cfg_dec_k;
        shadow_byp <= cfg_bypass;
      end
      if (flush_entry) begin
        cic_dec_k  <= shadow_k_d;
        cic_bypass <= shadow_byp_d;
      end
      cic_clr   <= (next_state == FLUSH);
      cfg_err   <= accept && !k_legal;
      out_valid <= (state == RUN) && (cic_bypass ? in_valid : wrap);
    end
  end

`ifdef CIC_DEC_CTRL_GAIN_EN
  localparam logic [3:0] ORDER_L = 4'(CIC_ORDER);

  // Normaliser shift, latched with the factor at flush entry; bypass needs none.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_shift <= 4'd0;
    end else if (flush_entry) begin
      gain_shift <= shadow_byp_d ? 4'd0 : ORDER_L * {1'b0, shadow_k_d};
    end
  end
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: a directed vector table for the
// reset/flush start-up, then hand-written sequences for cadence, config
// changes, illegal requests, enable drop, bypass and reset mid-flush.
module tb_cic_dec_ctrl;

  localparam int CIC_ORDER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_dec_k = 3'd0;
  logic       cfg_bypass = 1'b0;
  logic       cfg_err;
  logic       cic_en;
  logic       cic_clr;
  logic [2:0] cic_dec_k;
  logic       cic_bypass;
  logic       out_valid;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef CIC_DEC_CTRL_GAIN_EN
  logic [3:0] gain_shift;
`endif

  cic_dec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_dec_k  (cfg_dec_k),
    .cfg_bypass (cfg_bypass),
    .cfg_err    (cfg_err),
    .cic_en     (cic_en),
    .cic_clr    (cic_clr),
    .cic_dec_k  (cic_dec_k),
    .cic_bypass (cic_bypass),
    .out_valid  (out_valid),
    .busy       (busy),
`ifdef CIC_DEC_CTRL_GAIN_EN
    .gain_shift (gain_shift),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic       en;
    logic       iv;
    logic       cv;
    logic [2:0] k;
    logic       byp;
    logic       ready;
    logic       err;
    logic       cen;
    logic       clr;
    logic [2:0] dk;
    logic       dbyp;
    logic       ov;
    logic       busy;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   samp_cnt;
  logic exp_ov;
  logic exp_err;
  logic [2:0] exp_k;
  logic prev_iv;
  logic iv_r;
  vec_t tbl [6];

  function automatic vec_t mk(input logic en, input logic iv, input logic cv,
                              input logic [2:0] k, input logic byp,
                              input logic ready, input logic err, input logic cen,
                              input logic clr, input logic [2:0] dk, input logic dbyp,
                              input logic ov, input logic bsy);
    vec_t v;
    v.en = en; v.iv = iv; v.cv = cv; v.k = k; v.byp = byp;
    v.ready = ready; v.err = err; v.cen = cen; v.clr = clr;
    v.dk = dk; v.dbyp = dbyp; v.ov = ov; v.busy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check all observable outputs, advance one edge.
  task automatic apply_vec(input vec_t v, input string tag);
    enable = v.en; in_valid = v.iv; cfg_valid = v.cv;
    cfg_dec_k = v.k; cfg_bypass = v.byp;
    #1;
    chk({tag, ".cfg_ready"},  {7'd0, cfg_ready},  {7'd0, v.ready});
    chk({tag, ".cfg_err"},    {7'd0, cfg_err},    {7'd0, v.err});
    chk({tag, ".cic_en"},     {7'd0, cic_en},     {7'd0, v.cen});
    chk({tag, ".cic_clr"},    {7'd0, cic_clr},    {7'd0, v.clr});
    chk({tag, ".cic_dec_k"},  {5'd0, cic_dec_k},  {5'd0, v.dk});
    chk({tag, ".cic_bypass"}, {7'd0, cic_bypass}, {7'd0, v.dbyp});
    chk({tag, ".out_valid"},  {7'd0, out_valid},  {7'd0, v.ov});
    chk({tag, ".busy"},       {7'd0, busy},       {7'd0, v.busy});
    @(posedge clk); #1;
  endtask

  // One cycle after a flush: settle lasts CIC_ORDER*d samples, then a strobe
  // follows each sample whose post-flush count is a multiple of d.
  task automatic one_cycle(input logic iv, input logic cv, input logic [2:0] k,
                           input logic byp, input int d);
    logic exp_busy;
    enable = 1'b1; in_valid = iv; cfg_valid = cv; cfg_dec_k = k; cfg_bypass = byp;
    #1;
    exp_busy = (samp_cnt < CIC_ORDER * d);
    chk("cad.busy",      {7'd0, busy},      {7'd0, exp_busy});
    chk("cad.cfg_ready", {7'd0, cfg_ready}, {7'd0, !exp_busy});
    chk("cad.cic_en",    {7'd0, cic_en},    {7'd0, iv});
    chk("cad.out_valid", {7'd0, out_valid}, {7'd0, exp_ov});
    chk("cad.cfg_err",   {7'd0, cfg_err},   {7'd0, exp_err});
    chk("cad.cic_dec_k", {5'd0, cic_dec_k}, {5'd0, exp_k});
    chk("cad.cic_clr",   {7'd0, cic_clr},   8'd0);
    if (iv) samp_cnt++;
    exp_ov  = iv && (samp_cnt > CIC_ORDER * d) && ((samp_cnt % d) == 0);
    exp_err = cv && !exp_busy && (k > 3'd4);
    @(posedge clk); #1;
  endtask

  task automatic run_cycles(input int n, input int d, input bit rnd);
    for (int i = 0; i < n; i++) begin
      one_cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 3'd0, 1'b0, d);
    end
  endtask

  task automatic start_cad(input logic [2:0] k);
    samp_cnt = 0; exp_ov = 1'b0; exp_err = 1'b0; exp_k = k;
  endtask

  initial begin
    // Start-up table: reset state, illegal request in IDLE, 2-cycle flush, k = 2.
    //            en  iv  cv  k     byp   rdy err cen clr dk    byp ov  busy
    tbl[0] = mk(0, 0, 0, 3'd0, 0,   1, 0, 0, 1, 3'd0, 0, 0, 0);
    tbl[1] = mk(0, 1, 1, 3'd2, 0,   1, 0, 0, 0, 3'd0, 0, 0, 0);
    tbl[2] = mk(0, 0, 1, 3'd5, 0,   1, 0, 0, 0, 3'd0, 0, 0, 0);
    tbl[3] = mk(1, 1, 0, 3'd0, 0,   1, 1, 0, 0, 3'd0, 0, 0, 0);
    tbl[4] = mk(1, 1, 0, 3'd0, 0,   0, 0, 0, 1, 3'd2, 0, 0, 1);
    tbl[5] = mk(1, 1, 0, 3'd0, 0,   0, 0, 0, 1, 3'd2, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef CIC_DEC_CTRL_GAIN_EN
    chk("reset.gain_shift", {4'd0, gain_shift}, 8'd0);
`endif
    for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // k = 2: 12 settle samples, first strobe after sample 16, then every 4.
    start_cad(3'd2);
    run_cycles(30, 4, 1'b0);
    run_cycles(20, 4, 1'b1);

    // Change to k = 3 in RUN: flush, then 24 discarded samples, cadence 8.
    apply_vec(mk(1, 0, 1, 3'd3, 0, 1, exp_err, 0, 0, 3'd2, 0, exp_ov, 0), "k3.req");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 1), "k3.fl0");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 1), "k3.fl1");
    start_cad(3'd3);
    run_cycles(40, 8, 1'b0);
    run_cycles(16, 8, 1'b1);

    // Identical request: no flush, cadence continues.
    one_cycle(1'b1, 1'b1, 3'd3, 1'b0, 8);
    run_cycles(20, 8, 1'b1);

    // Illegal request k = 5: one cfg_err pulse, nothing else changes.
    one_cycle(1'b1, 1'b1, 3'd5, 1'b0, 8);
    run_cycles(12, 8, 1'b0);

    // Move to k = 1, then drop enable mid-SETTLE for 3 cycles.
    apply_vec(mk(1, 0, 1, 3'd1, 0, 1, exp_err, 0, 0, 3'd3, 0, exp_ov, 0), "k1.req");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1), "k1.fl0");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1), "k1.fl1");
    start_cad(3'd1);
    run_cycles(3, 2, 1'b0);
    apply_vec(mk(0, 1, 0, 3'd0, 0, 0, 0, 1, 0, 3'd1, 0, 0, 1), "drop.settle");
    apply_vec(mk(0, 1, 0, 3'd0, 0, 1, 0, 0, 0, 3'd1, 0, 0, 0), "drop.idle0");
    apply_vec(mk(0, 1, 0, 3'd0, 0, 1, 0, 0, 0, 3'd1, 0, 0, 0), "drop.idle1");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 1, 0, 0, 0, 3'd1, 0, 0, 0), "drop.reen");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1), "drop.fl0");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 1), "drop.fl1");
    start_cad(3'd1);
    run_cycles(11, 2, 1'b0);

    // Bypass: flush, straight to RUN, out_valid is in_valid delayed by one.
    apply_vec(mk(1, 0, 1, 3'd1, 1, 1, 0, 0, 0, 3'd1, 0, 0, 0), "byp.req");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd1, 1, 0, 1), "byp.fl0");
`ifdef CIC_DEC_CTRL_GAIN_EN
    chk("byp.gain_shift", {4'd0, gain_shift}, 8'd0);
`endif
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd1, 1, 0, 1), "byp.fl1");
    prev_iv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      iv_r = 1'($urandom_range(0, 1));
      apply_vec(mk(1, iv_r, 0, 3'd0, 0, 1, 0, iv_r, 0, 3'd1, 1, prev_iv, 0), "byp.run");
      prev_iv = iv_r;
    end

    // k = 4 (D = 16, largest legal factor): 48 discarded, strobe after 64.
    apply_vec(mk(1, 0, 1, 3'd4, 0, 1, 0, 0, 0, 3'd1, 1, prev_iv, 0), "k4.req");
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 1), "k4.fl0");
`ifdef CIC_DEC_CTRL_GAIN_EN
    chk("k4.gain_shift", {4'd0, gain_shift}, 8'd12);
`endif
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 1), "k4.fl1");
    start_cad(3'd4);
    run_cycles(66, 16, 1'b0);

    // Reset asserted mid-FLUSH returns everything to the reset state.
    apply_vec(mk(1, 0, 1, 3'd2, 0, 1, 0, 0, 0, 3'd4, 0, 0, 0), "rst.req");
    rst = 1'b1;
    apply_vec(mk(1, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'd2, 0, 0, 1), "rst.fl0");
    rst = 1'b0;
`ifdef CIC_DEC_CTRL_GAIN_EN
    chk("rst.gain_shift", {4'd0, gain_shift}, 8'd0);
`endif
    apply_vec(mk(0, 1, 0, 3'd0, 0, 1, 0, 0, 1, 3'd0, 0, 0, 0), "rst.state");
    apply_vec(mk(0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0), "rst.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
